// File: rtl/trigger_scheduler.sv
// Trigger acceptance for the sampling_clk domain: arbitrates external vs internal triggers,
// applies mode mask, dead time and FIFO back-pressure, and queues tagged event records.
module trigger_scheduler #(
  parameter int DEPTH    = 4,
  parameter int DEADTIME = 16
) (
  input  logic        sampling_clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        ext_valid,
  input  logic [15:0] ext_id,
  input  logic [63:0] ext_cycle,
  input  logic        int_trigger,
  input  logic [63:0] cycle,
  input  logic        evt_ready,
  output logic        evt_valid,
  output logic        evt_source,
  output logic [15:0] evt_id,
  output logic [63:0] evt_cycle,
  output logic        busy,
  output logic [15:0] dropped
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [DW-1:0] DT_LOAD  = DW'(DEADTIME);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  logic          int_prev;
  logic [15:0]   int_seq;
  logic [DW-1:0] dt_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          busy_q;
  logic [15:0]   dropped_q;

  logic          mem_source [DEPTH];
  logic [15:0]   mem_id     [DEPTH];
  logic [63:0]   mem_cycle  [DEPTH];

  logic          ext_cand;
  logic          int_cand;
  logic          can_accept;
  logic          accept;
  logic          accept_int;
  logic          pop;
  logic [1:0]    n_cand;
  logic [1:0]    n_rej;
  logic [16:0]   dropped_sum;
  logic [15:0]   dropped_nxt;
  logic [OW-1:0] occ_nxt;
  logic [DW-1:0] dt_nxt;
  logic          busy_nxt;

  // Acceptance uses pre-pop occupancy, so a same-cycle pop never makes room.
  always_comb begin
    ext_cand   = ext_valid & mode[0];
    int_cand   = int_trigger & ~int_prev & mode[1];
    can_accept = (dt_cnt == '0) && (occ != OCC_FULL);
    accept     = (ext_cand | int_cand) & can_accept;
    accept_int = accept & ~ext_cand;
    pop        = (occ != '0) & evt_ready;

    n_cand      = {1'b0, ext_cand} + {1'b0, int_cand};
    n_rej       = n_cand - {1'b0, accept};
    dropped_sum = {1'b0, dropped_q} + {15'd0, n_rej};
    dropped_nxt = dropped_sum[16] ? 16'hFFFF : dropped_sum[15:0];

    occ_nxt = occ;
    if (accept && !pop) begin
      occ_nxt = occ + OW'(1);
    end else if (pop && !accept) begin
      occ_nxt = occ - OW'(1);
    end

    dt_nxt = dt_cnt;
    if (accept) begin
      dt_nxt = DT_LOAD;
    end else if (dt_cnt != '0) begin
      dt_nxt = dt_cnt - DW'(1);
    end

    busy_nxt = (dt_nxt != '0) | (occ_nxt == OCC_FULL);
  end

  always_ff @(posedge sampling_clk) begin
    if (reset) begin
      int_prev  <= 1'b0;
      int_seq   <= 16'd0;
      dt_cnt    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      busy_q    <= 1'b0;
      dropped_q <= 16'd0;
    end else begin
      int_prev  <= int_trigger;
      dt_cnt    <= dt_nxt;
      occ       <= occ_nxt;
      busy_q    <= busy_nxt;
      dropped_q <= dropped_nxt;
      if (accept_int) begin
        int_seq <= int_seq + 16'd1;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage is cleared on reset so the idle head reads back as zeros.
  always_ff @(posedge sampling_clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_source[i] <= 1'b0;
        mem_id[i]     <= 16'd0;
        mem_cycle[i]  <= 64'd0;
      end
    end else if (accept) begin
      mem_source[wr_ptr] <= accept_int;
      mem_id[wr_ptr]     <= accept_int ? int_seq : ext_id;
      mem_cycle[wr_ptr]  <= accept_int ? cycle : ext_cycle;
    end
  end

  assign evt_valid  = (occ != '0);
  assign evt_source = mem_source[rd_ptr];
  assign evt_id     = mem_id[rd_ptr];
  assign evt_cycle  = mem_cycle[rd_ptr];
  assign busy       = busy_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_trigger_scheduler.sv
// Self-checking bench for trigger_scheduler: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_trigger_scheduler;

  localparam int DEPTH = 4;
  localparam int DT    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        ev;
  logic [15:0] eid;
  logic [63:0] ecyc;
  logic        it;
  logic [63:0] cyc_cnt = 64'h1000;
  logic        ready;
  logic        evt_valid;
  logic        evt_source;
  logic [15:0] evt_id;
  logic [63:0] evt_cycle;
  logic        busy;
  logic [15:0] dropped;

  int n_chk = 0;
  int n_err = 0;

  trigger_scheduler #(.DEPTH(DEPTH), .DEADTIME(DT)) dut (
    .sampling_clk(clk),
    .reset(reset),
    .mode(mode),
    .ext_valid(ev),
    .ext_id(eid),
    .ext_cycle(ecyc),
    .int_trigger(it),
    .cycle(cyc_cnt),
    .evt_ready(ready),
    .evt_valid(evt_valid),
    .evt_source(evt_source),
    .evt_id(evt_id),
    .evt_cycle(evt_cycle),
    .busy(busy),
    .dropped(dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 64'd1;

  typedef struct {
    logic [1:0]  mode;
    logic        ev;
    logic [15:0] eid;
    logic [63:0] ecyc;
    logic        it;
    logic        rdy;
    logic        x_valid;
    logic        x_src;
    logic [15:0] x_id;
    logic [63:0] x_cyc;
    logic        x_busy;
    logic [15:0] x_drop;
  } vec_t;

  typedef struct {
    logic        src;
    logic [15:0] id;
    logic [63:0] cy;
  } rec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ev = 1'b0;
    it = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    mode  = 2'b00;
    ev    = 1'b0;
    eid   = 16'd0;
    ecyc  = 64'd0;
    it    = 1'b0;
    ready = 1'b0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic pulse_ext(input logic [15:0] id, input logic [63:0] cy);
    ev   = 1'b1;
    eid  = id;
    ecyc = cy;
    step();
    ev = 1'b0;
  endtask

  // Reference model state
  rec_t        q[$];
  int          m_drop;
  int          m_k;
  int          m_next_ok;
  logic [15:0] m_seq;
  logic        m_prev;

  task automatic model_cycle();
    logic ext_c, int_c, can, acc;
    int   ncand;
    rec_t r;
    chk("rnd_valid", evt_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("rnd_src", evt_source, q[0].src);
      chk("rnd_id", evt_id, q[0].id);
      chk("rnd_cycle", evt_cycle, q[0].cy);
    end
    chk("rnd_busy", busy, (m_k < m_next_ok) || (q.size() == DEPTH));
    chk("rnd_dropped", dropped, m_drop);

    ext_c = ev & mode[0];
    int_c = it & ~m_prev & mode[1];
    can   = (m_k >= m_next_ok) && (q.size() < DEPTH);
    acc   = (ext_c | int_c) & can;
    ncand = int'(ext_c) + int'(int_c);
    if (q.size() != 0 && ready) void'(q.pop_front());
    if (acc) begin
      if (ext_c) begin
        r.src = 1'b0; r.id = eid; r.cy = ecyc;
      end else begin
        r.src = 1'b1; r.id = m_seq; r.cy = cyc_cnt;
        m_seq = m_seq + 16'd1;
      end
      q.push_back(r);
      m_next_ok = m_k + DT + 1;
    end
    m_drop = m_drop + ncand - int'(acc);
    if (m_drop > 65535) m_drop = 65535;
    m_prev = it;
    m_k++;
  endtask

  initial begin
    // Directed vector table (rows applied on consecutive cycles after reset)
    tbl[0]  = '{2'b01, 1'b1, 16'hBEEF, 64'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 64'h1234, 1'b1, 16'd0};
    tbl[1]  = '{2'b11, 1'b1, 16'h1111, 64'h77,   1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 64'h1234, 1'b1, 16'd2};
    tbl[2]  = '{2'b00, 1'b1, 16'h2222, 64'h0,    1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 64'h1234, 1'b1, 16'd2};
    tbl[3]  = '{2'b10, 1'b0, 16'h0,    64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 64'h1234, 1'b1, 16'd3};
    tbl[4]  = '{2'b00, 1'b0, 16'h0,    64'h0,    1'b0, 1'b1, 1'b0, 1'b0, 16'h0,    64'h0,    1'b1, 16'd3};
    for (int i = 5; i <= 16; i++)
      tbl[i] = '{2'b00, 1'b0, 16'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0, (i <= 15), 16'd3};
    tbl[17] = '{2'b11, 1'b1, 16'h2222, 64'h55,   1'b1, 1'b0, 1'b1, 1'b0, 16'h2222, 64'h55,   1'b1, 16'd4};
    tbl[18] = '{2'b00, 1'b0, 16'h0,    64'h0,    1'b0, 1'b1, 1'b0, 1'b0, 16'h0,    64'h0,    1'b1, 16'd4};

    do_reset(2);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_source", evt_source, 1'b0);
    chk("rst_id", evt_id, 16'd0);
    chk("rst_cycle", evt_cycle, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dropped", dropped, 16'd0);

    for (int i = 0; i < 19; i++) begin
      mode = tbl[i].mode; ev = tbl[i].ev; eid = tbl[i].eid; ecyc = tbl[i].ecyc;
      it = tbl[i].it; ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), evt_valid, tbl[i].x_valid);
      if (tbl[i].x_valid) begin
        chk($sformatf("tbl%0d_src", i), evt_source, tbl[i].x_src);
        chk($sformatf("tbl%0d_id", i), evt_id, tbl[i].x_id);
        chk($sformatf("tbl%0d_cycle", i), evt_cycle, tbl[i].x_cyc);
      end
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].x_busy);
      chk($sformatf("tbl%0d_dropped", i), dropped, tbl[i].x_drop);
    end

    // Dead-time rejection: triggers at A, A+5, A+17
    ready = 1'b1; mode = 2'b01;
    idle(20);
    pulse_ext(16'hA001, 64'd10);
    chk("dt_first_id", evt_id, 16'hA001);
    idle(4);
    pulse_ext(16'hA002, 64'd11);
    chk("dt_second_valid", evt_valid, 1'b0);
    chk("dt_second_dropped", dropped, 16'd5);
    idle(10);
    chk("dt_busy_last", busy, 1'b1);
    idle(1);
    chk("dt_busy_clear", busy, 1'b0);
    pulse_ext(16'hA003, 64'd12);
    chk("dt_third_valid", evt_valid, 1'b1);
    chk("dt_third_id", evt_id, 16'hA003);
    chk("dt_third_dropped", dropped, 16'd5);

    // FIFO full with internal triggers; sequence counter untouched so far
    idle(20);
    ready = 1'b0; mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      it = 1'b1;
      step();
      it = 1'b0;
      chk($sformatf("full%0d_head", i), evt_id, 16'd0);
      chk($sformatf("full%0d_src", i), evt_source, 1'b1);
      if (i == 3) chk("full_busy_4th", busy, 1'b1);
      idle(16);
    end
    chk("full_busy_occ", busy, 1'b1);
    chk("full_dropped", dropped, 16'd6);
    it = 1'b1; ready = 1'b1;
    step();
    it = 1'b0; ready = 1'b0;
    chk("poppush_dropped", dropped, 16'd7);
    chk("poppush_busy", busy, 1'b0);
    ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      chk($sformatf("drain%0d_valid", j), evt_valid, 1'b1);
      chk($sformatf("drain%0d_id", j), evt_id, 16'(j));
      step();
    end
    chk("drain_empty", evt_valid, 1'b0);

    // Saturation: fill FIFO, then two candidates on alternate cycles
    ready = 1'b0; mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      pulse_ext(16'hB000 + 16'(i), 64'(i));
      idle(16);
    end
    for (int c = 0; c < 44000; c++) begin
      ev = 1'b1;
      it = (c % 2 == 0);
      step();
      if (c == 19999) chk("sat_partial", dropped, 16'd30007);
    end
    idle(1);
    chk("sat_dropped", dropped, 16'hFFFF);

    // Reset mid-run with 3 queued entries and dead time running
    ready = 1'b1;
    idle(2);
    ready = 1'b0;
    pulse_ext(16'hC001, 64'd99);
    chk("pre_rst_busy", busy, 1'b1);
    do_reset(1);
    chk("midrst_valid", evt_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_dropped", dropped, 16'd0);
    chk("midrst_id", evt_id, 16'd0);
    mode = 2'b01;
    pulse_ext(16'hC0DE, 64'hFEED);
    chk("postrst_valid", evt_valid, 1'b1);
    chk("postrst_id", evt_id, 16'hC0DE);
    chk("postrst_cycle", evt_cycle, 64'hFEED);

    // Randomized run against the reference model
    do_reset(1);
    q.delete();
    m_drop = 0; m_k = 0; m_next_ok = 0; m_seq = 16'd0; m_prev = 1'b0;
    mode = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      ev    = ($urandom_range(0, 3) == 0);
      eid   = 16'($urandom);
      ecyc  = {$urandom, $urandom};
      it    = ($urandom_range(0, 2) == 0) ? ~it : it;
      ready = ($urandom_range(0, 3) == 0);
      model_cycle();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_scheduler.md
# trigger_scheduler

Sequences and arbitrates trigger acceptance between the external (TLU-decoded) trigger path and the internal coincidence trigger, all in the `sampling_clk` domain. It enforces a mode mask, a programmable dead time and back-pressure. It tags each accepted trigger with source, ID and cycle timestamp, and queues the record in a small FIFO for the readout logic. It drives the `busy` line back toward the trigger source and keeps a saturating count of rejected triggers.

## Interface
- `DEPTH`, 4: event FIFO depth; power of two, ≥2.
- `DEADTIME`, 16: cycles after each accept during which new triggers are rejected; 0 disables dead time.

- `sampling_clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `mode`  in  2  bit0 enables external, bit1 enables internal; sampled every cycle.
- `ext_valid`  in  1  single-cycle pulse: external trigger decode complete.
- `ext_id`  in  16  external trigger ID, valid with `ext_valid`.
- `ext_cycle`  in  64  external trigger timestamp, valid with `ext_valid`.
- `int_trigger`  in  1  internal trigger level; rising edge = one trigger.
- `cycle`  in  64  free-running cycle reference; used to timestamp internal triggers.
- `evt_ready`  in  1  readout consumer ready.
- `evt_valid`  out  1  FIFO head valid.
- `evt_source`  out  1  0 = external, 1 = internal.
- `evt_id`  out  16  external ID, or internal sequence number.
- `evt_cycle`  out  64  trigger timestamp.
- `busy`  out  1  new triggers will currently be rejected.
- `dropped`  out  16  rejected-trigger count, saturating.

## Operation
- **Edge detect:** internal candidate when `int_trigger`=1 and its registered previous value=0. The edge-detect register resets to 0, so a level already high at reset release counts as a trigger.
- **Candidates:** external when `ext_valid`=1 and `mode[0]`=1; internal when edge and `mode[1]`=1. Triggers from a disabled source are ignored, not counted as dropped.
- **Arbitration:** if both candidates occur in one cycle, external wins; the internal one counts as dropped.
- **Acceptance:** a candidate is accepted iff dead-time counter = 0 and FIFO occupancy < `DEPTH`, using pre-pop occupancy. A pop in the same cycle does not free a slot for a push in that cycle.
- **Internal records:** `id` = internal sequence counter (16-bit, starts at 0, increments per accepted internal trigger, wraps 0xFFFF→0x0000); `cycle` = `cycle` input in the detection cycle.
- **External records:** `ext_id` and `ext_cycle` are stored unmodified.
- **Rejection:** each rejected candidate increments `dropped` by 1, saturating at 0xFFFF. A cycle with two candidates and no acceptance increments by 2, also saturating.
- **Dead-time counter:** loaded with `DEADTIME` on accept; otherwise decrements toward 0 every cycle.
- **FIFO:** circular buffer of {source, id[15:0], cycle[63:0]}, occupancy 0..`DEPTH`. Pointers wrap modulo `DEPTH`. Pop when `evt_valid` & `evt_ready`. `evt_*` show the head entry combinationally from the storage array; `evt_valid` = occupancy ≠ 0.
- **busy:** (dead-time counter ≠ 0) | (occupancy = `DEPTH`), registered from next-state values so it is exact in the cycle it is asserted.
- **Mode change:** takes effect the same cycle; queued entries are unaffected.
- **Reset values:** `evt_valid`=0, `evt_source`=0, `evt_id`=0, `evt_cycle`=0, `busy`=0, `dropped`=0. Internal sequence counter, dead-time counter, pointers, occupancy and edge-detect register are all 0. Reset mid-operation discards queued entries.

## Timing
- Accept at edge N (`ext_valid` or internal edge present in cycle N) → entry written at edge N. `evt_valid`=1 from cycle N+1 if the FIFO was empty.
- Dead time: accept in cycle N → `busy`=1 in cycles N+1..N+`DEADTIME`. Candidates in those cycles are dropped; a candidate in cycle N+`DEADTIME`+1 is accepted.
- Pop at edge M → next entry (or `evt_valid`=0) visible in cycle M+1.
- `evt_ready` may be held high indefinitely; `evt_*` are stable while `evt_valid`=1 and `evt_ready`=0.

## Test plan
- **Single external trigger:** `DEADTIME`=16, `mode`=01, `ext_valid` pulse with id 0xBEEF, cycle 0x1234 → next cycle `evt_valid`=1, source 0, id 0xBEEF, cycle 0x1234. `busy` is high for exactly 16 cycles.
- **Dead-time rejection:** external triggers 5 and 17 cycles apart, `DEADTIME`=16 → first accepted, second dropped (`dropped`=1). A third trigger 17 cycles after the first is accepted.
- **Simultaneous sources:** `mode`=11, `ext_valid` and internal rising edge in the same cycle → one external entry; `dropped`=1; internal sequence counter stays 0.
- **FIFO full:** `DEADTIME`=0, `evt_ready`=0, 5 internal triggers → 4 entries with ids 0..3, `busy`=1 after the 4th, `dropped`=1. Pop one and push in the same cycle → push dropped (`dropped`=2).
- **Saturation and wrap:** force 0x10001 drops → `dropped`=0xFFFF. Accept 0x10001 internal triggers → last id 0x0000.
- **Reset mid-run:** reset with 3 entries queued and dead time active → next cycle `evt_valid`=0, `busy`=0, `dropped`=0. A trigger in the first cycle after reset is accepted.
